// File: rtl/conv_pkg.sv
// Shared FSM encoding and layout/address arithmetic for the convolution engine.
// Image is HWC, weights are [oc][ky][kx][ic], outputs are HWC.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // Signed image coordinate touched by a kernel tap; negative means top/left padding.
  function automatic int tap_coord(int o, int k, int stride, int pad);
    return o * stride + k - pad;
  endfunction

  function automatic logic in_image(int row, int col, int dim);
    return (row >= 0) && (row < dim) && (col >= 0) && (col < dim);
  endfunction

  function automatic logic [15:0] img_addr_of(int row, int col, int ch, int img_dim, int in_ch);
    return 16'((row * img_dim + col) * in_ch + ch);
  endfunction

  function automatic logic [15:0] w_addr_of(int oc, int ky, int kx, int ic, int kdim, int in_ch);
    return 16'(oc * kdim * kdim * in_ch + (ky * kdim + kx) * in_ch + ic);
  endfunction

  function automatic logic [15:0] out_addr_of(int orow, int ocol, int oc, int out_dim, int out_ch);
    return 16'((orow * out_dim + ocol) * out_ch + oc);
  endfunction

endpackage

// File: rtl/conv_layer_engine_if.sv
// Control handshake plus the three read ports and one write port of the engine.
// All memories sit outside; reads return data one cycle after the address.
interface conv_layer_engine_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] img_addr;
  logic [7:0]  img_data;
  logic [15:0] w_addr;
  logic [7:0]  w_data;
  logic [7:0]  b_addr;
  logic [7:0]  b_data;
  logic        out_we;
  logic [15:0] out_addr;
  logic [7:0]  out_data;

  modport master (
    input  start, img_data, w_data, b_data,
    output busy, done, img_addr, w_addr, b_addr, out_we, out_addr, out_data
  );

  modport slave (
    output start, img_data, w_data, b_data,
    input  busy, done, img_addr, w_addr, b_addr, out_we, out_addr, out_data
  );
endinterface

// File: rtl/conv_mac.sv
// Masked multiply-accumulate one cycle behind the tap addresses, plus the
// bias/shift/saturate stage that produces the registered output byte.
module conv_mac #(
  parameter int BIAS_SHIFT   = 6,
  parameter int OUT_SHIFT    = 9,
  parameter int INPUT_SIGNED = 0,
  parameter int RELU         = 0,
  parameter int ACC_W        = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,       // BIAS cycle
  input  logic       bias_issue,  // b_addr valid this cycle
  input  logic       tap_issue,   // tap address valid this cycle
  input  logic       tap_inb,     // that tap lies inside the image
  input  logic       finish,      // DRAIN cycle: last product arrives now
  input  logic [7:0] img_data,
  input  logic [7:0] w_data,
  input  logic [7:0] b_data,
  output logic [7:0] out_data
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  logic                    take_d, inb_d, bias_d;
  logic signed [7:0]       bias_q;
  logic signed [16:0]      w_x, img_x, prod;
  logic signed [ACC_W-1:0] acc, acc_next, bias_ext, sum, shifted;
  logic [7:0]              result;

  // NOTE: every variable gets a value on every path through always_comb, so no latch can be inferred.
  always_comb begin
    w_x      = 17'($signed(w_data));
    img_x    = (INPUT_SIGNED != 0) ? 17'($signed(img_data)) : 17'(img_data);
    prod     = w_x * img_x;
    acc_next = acc + ((take_d && inb_d) ? ACC_W'(prod) : '0);
    bias_ext = ACC_W'(bias_q) <<< BIAS_SHIFT;
    sum      = acc_next + bias_ext;
    shifted  = sum >>> OUT_SHIFT;
    if (shifted > SAT_HI)      result = 8'h7f;
    else if (shifted < SAT_LO) result = 8'h80;
    else                       result = shifted[7:0];
    if ((RELU != 0) && result[7]) result = 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      take_d   <= 1'b0;
      inb_d    <= 1'b0;
      bias_d   <= 1'b0;
      bias_q   <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      take_d <= tap_issue;
      inb_d  <= tap_inb;
      bias_d <= bias_issue;
      if (bias_d) bias_q <= b_data;
      if (clear) acc <= '0;
      else       acc <= acc_next;
      // The final tap is folded in here via acc_next, so the result is ready for WRITE.
      if (finish) out_data <= result;
    end
  end

endmodule

// File: rtl/conv_layer_engine.sv
// Whole-layer 2D convolution sequencer: walks outputs (orow, ocol, oc) and taps
// (ky, kx, ic), issuing registered addresses one tap per cycle into conv_mac.
module conv_layer_engine
  import conv_pkg::*;
#(
  parameter int IMG_DIM      = 32,
  parameter int IN_CH        = 3,
  parameter int OUT_CH       = 32,
  parameter int KERNEL_DIM   = 5,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 2,
  parameter int BIAS_SHIFT   = 6,
  parameter int OUT_SHIFT    = 9,
  parameter int INPUT_SIGNED = 0,
  parameter int RELU         = 0,
  parameter int ACC_W        = 32
) (
  input logic                 clk,
  input logic                 reset_n,
  conv_layer_engine_if.master bus
);

  localparam int OUT_DIM = (IMG_DIM + 2 * PADDING - KERNEL_DIM) / STRIDE + 1;
  localparam int TAPS    = KERNEL_DIM * KERNEL_DIM * IN_CH;

  localparam logic [15:0] K_LAST   = 16'(KERNEL_DIM - 1);
  localparam logic [15:0] IC_LAST  = 16'(IN_CH - 1);
  localparam logic [15:0] OC_LAST  = 16'(OUT_CH - 1);
  localparam logic [15:0] OD_LAST  = 16'(OUT_DIM - 1);
  localparam logic [15:0] TAP_LAST = 16'(TAPS - 1);

  state_t      state;
  logic [15:0] orow, ocol, oc, oc_next;
  logic [15:0] ky, kx, ic;  // next tap to issue
  logic [15:0] mac_cnt;
  logic        inb_q, tap_inb, issue_now, last_out;
  int          tap_row, tap_col;

  always_comb begin
    tap_row   = tap_coord(int'(orow), int'(ky), STRIDE, PADDING);
    tap_col   = tap_coord(int'(ocol), int'(kx), STRIDE, PADDING);
    tap_inb   = in_image(tap_row, tap_col, IMG_DIM);
    issue_now = (state == S_BIAS) || ((state == S_MAC) && (mac_cnt != TAP_LAST));
    last_out  = (oc == OC_LAST) && (ocol == OD_LAST) && (orow == OD_LAST);
    oc_next   = (oc == OC_LAST) ? '0 : oc + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      orow         <= '0;
      ocol         <= '0;
      oc           <= '0;
      ky           <= '0;
      kx           <= '0;
      ic           <= '0;
      mac_cnt      <= '0;
      inb_q        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.img_addr <= '0;
      bus.w_addr   <= '0;
      bus.b_addr   <= '0;
      bus.out_we   <= 1'b0;
      bus.out_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state      <= S_BIAS;
          bus.busy   <= 1'b1;
          orow       <= '0;
          ocol       <= '0;
          oc         <= '0;
          ky         <= '0;
          kx         <= '0;
          ic         <= '0;
          bus.b_addr <= '0;
        end
        S_BIAS: begin
          state   <= S_MAC;
          mac_cnt <= '0;
        end
        S_MAC: begin
          if (mac_cnt == TAP_LAST) state <= S_DRAIN;
          else mac_cnt <= mac_cnt + 16'd1;
        end
        S_DRAIN: begin
          state        <= S_WRITE;
          bus.out_we   <= 1'b1;
          bus.out_addr <= out_addr_of(int'(orow), int'(ocol), int'(oc), OUT_DIM, OUT_CH);
        end
        S_WRITE: begin
          bus.out_we <= 1'b0;
          ky         <= '0;
          kx         <= '0;
          ic         <= '0;
          if (last_out) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            state      <= S_BIAS;
            oc         <= oc_next;
            bus.b_addr <= oc_next[7:0];
            if (oc == OC_LAST) begin
              if (ocol == OD_LAST) begin
                ocol <= '0;
                orow <= orow + 16'd1;
              end else begin
                ocol <= ocol + 16'd1;
              end
            end
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Padding taps still occupy a cycle; their address is parked at 0 and the data masked.
      if (issue_now) begin
        inb_q        <= tap_inb;
        bus.img_addr <= tap_inb ? img_addr_of(tap_row, tap_col, int'(ic), IMG_DIM, IN_CH) : '0;
        bus.w_addr   <= w_addr_of(int'(oc), int'(ky), int'(kx), int'(ic), KERNEL_DIM, IN_CH);
        if (ic == IC_LAST) begin
          ic <= '0;
          if (kx == K_LAST) begin
            kx <= '0;
            ky <= ky + 16'd1;
          end else begin
            kx <= kx + 16'd1;
          end
        end else begin
          ic <= ic + 16'd1;
        end
      end
    end
  end

  conv_mac #(
    .BIAS_SHIFT  (BIAS_SHIFT),
    .OUT_SHIFT   (OUT_SHIFT),
    .INPUT_SIGNED(INPUT_SIGNED),
    .RELU        (RELU),
    .ACC_W       (ACC_W)
  ) u_mac (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (state == S_BIAS),
    .bias_issue(state == S_BIAS),
    .tap_issue (state == S_MAC),
    .tap_inb   (inb_q),
    .finish    (state == S_DRAIN),
    .img_data  (bus.img_data),
    .w_data    (bus.w_data),
    .b_data    (bus.b_data),
    .out_data  (bus.out_data)
  );

endmodule
